sprite_rom_arbiter: RTL

Shares one single-port, registered-output sprite image ROM (160x120 pixels, 12-bit RGB444 words) between two requesters. The VGA pixel-fetch path has fixed-latency priority, and the game-logic port (collision and pixel probes) uses a request/acknowledge handshake. A starvation guard bounds game-logic wait time. The block sits between the display image generator, the game FSM and the R/G/B ROM instances.

---
 rtl/sprite_rom_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares one registered sprite ROM between the
// fixed-latency VGA fetch path and a req/ack game-logic port.
module sprite_rom_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 12,
  parameter int DEPTH    = 19200,
  parameter int MAX_WAIT = 1024,
  parameter int WAIT_W   = 11
) (
  input  logic              iVGA_CLK,
  input  logic              iRST,
  input  logic              iDISP_REQ,
  input  logic [ADDR_W-1:0] iDISP_ADDR,
  output logic [DATA_W-1:0] oDISP_DATA,
  output logic              oDISP_VALID,
  output logic              oDISP_MISS,
  input  logic              iCPU_REQ,
  input  logic [ADDR_W-1:0] iCPU_ADDR,
  output logic              oCPU_ACK,
  output logic [DATA_W-1:0] oCPU_DATA,
  output logic [ADDR_W-1:0] oROM_ADDR,
  input  logic [DATA_W-1:0] iROM_DATA
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FLIGHT,
    S_ACK
  } cpu_st_e;

  typedef struct packed {
    logic disp;
    logic cpu;
    logic miss;
    logic oor;
  } tag_t;

  localparam logic [31:0]       DEPTH_U  = 32'(DEPTH);
  localparam logic [WAIT_W-1:0] MAX_C    = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] ONE_C    = WAIT_W'(1);
  localparam bit                FORCE_EN = (MAX_WAIT != 0);

  cpu_st_e           state_q, state_d;
  logic              flight_q, flight_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic              force_c;
  logic              grant_disp;
  logic              grant_cpu;
  logic              drop_disp;

  logic [ADDR_W-1:0] sel_addr;
  logic              sel_oor;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  tag_t              tag1_q, tag1_d;
  tag_t              tag2_q;
  logic [DATA_W-1:0] rd_data;

  logic [DATA_W-1:0] disp_data_q;
  logic              disp_valid_q;
  logic              disp_miss_q;
  logic              cpu_ack_q;
  logic [DATA_W-1:0] cpu_data_q;

  // Game-port FSM: state register
  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= S_IDLE;
      flight_q <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      flight_q <= flight_d;
      wait_q   <= wait_d;
    end
  end

  // Game-port FSM: next state
  always_comb begin
    state_d  = state_q;
    flight_d = flight_q;
    wait_d   = wait_q;
    unique case (state_q)
      S_IDLE: begin
        wait_d   = '0;
        flight_d = 1'b0;
        if (iCPU_REQ) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (grant_cpu) begin
          state_d  = S_FLIGHT;
          flight_d = 1'b0;
          wait_d   = '0;
        end else if (wait_q != MAX_C) begin
          wait_d = wait_q + ONE_C;
        end
      end
      S_FLIGHT: begin
        wait_d   = '0;
        flight_d = ~flight_q;
        if (flight_q) state_d = S_ACK;
      end
      S_ACK: begin
        flight_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Game-port FSM: slot ownership outputs
  always_comb begin
    force_c    = 1'b0;
    grant_disp = 1'b0;
    grant_cpu  = 1'b0;
    drop_disp  = 1'b0;
    if (FORCE_EN && state_q == S_WAIT && wait_q == MAX_C)
      force_c = 1'b1;
    grant_disp = iDISP_REQ & ~force_c;
    grant_cpu  = (state_q == S_WAIT) & ~grant_disp;
    drop_disp  = iDISP_REQ & force_c;
  end

  // Out-of-range reads park the ROM at 0 and return zero data
  always_comb begin
    sel_addr   = grant_disp ? iDISP_ADDR : iCPU_ADDR;
    sel_oor    = 32'(sel_addr) >= DEPTH_U;
    rom_addr_d = rom_addr_q;
    tag1_d      = '0;
    tag1_d.disp = grant_disp;
    tag1_d.cpu  = grant_cpu;
    tag1_d.miss = drop_disp;
    if (grant_disp || grant_cpu) begin
      tag1_d.oor = sel_oor;
      rom_addr_d = sel_oor ? '0 : sel_addr;
    end
  end

  assign rd_data = tag2_q.oor ? '0 : iROM_DATA;

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      rom_addr_q   <= '0;
      tag1_q       <= '0;
      tag2_q       <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      disp_miss_q  <= 1'b0;
      cpu_ack_q    <= 1'b0;
      cpu_data_q   <= '0;
    end else begin
      rom_addr_q   <= rom_addr_d;
      tag1_q       <= tag1_d;
      tag2_q       <= tag1_q;
      disp_valid_q <= tag2_q.disp;
      disp_miss_q  <= tag2_q.miss;
      cpu_ack_q    <= tag2_q.cpu;
      if (tag2_q.disp) disp_data_q <= rd_data;
      if (tag2_q.cpu)  cpu_data_q  <= rd_data;
    end
  end

  assign oROM_ADDR   = rom_addr_q;
  assign oDISP_DATA  = disp_data_q;
  assign oDISP_VALID = disp_valid_q;
  assign oDISP_MISS  = disp_miss_q;
  assign oCPU_ACK    = cpu_ack_q;
  assign oCPU_DATA   = cpu_data_q;

endmodule
